// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the memory-access stage and dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM, LED toggle register, cycle timer, wait states
// Optional DMEM_MISALIGN_ERR_EN: misaligned requests are not performed and answer with rsp_err.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] TOGGLE_ADDR = 32'h34,
  parameter logic [31:0] TIMER_ADDR  = 32'h38
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [31:0]        toggle_value
);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] toggle_q;
  logic [31:0] timer_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic        bad_q;
  logic [3:0]  cnt_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        misal;
  logic        hit_toggle;
  logic        hit_timer;
  logic        hit_ram;
  logic        wr_ram;
  logic        wr_toggle;

  assign accept = bus.req_valid & ready_q;

`ifdef DMEM_MISALIGN_ERR_EN
  assign misal = |bus.req_addr[1:0];
`else
  assign misal = 1'b0;
`endif

  assign hit_toggle = (bus.req_addr == TOGGLE_ADDR);
  assign hit_timer  = (bus.req_addr == TIMER_ADDR);
  assign hit_ram    = (bus.req_addr < RAM_BYTES);
  assign wr_ram     = accept & bus.req_we & ~misal & ~hit_toggle & ~hit_timer & hit_ram;
  assign wr_toggle  = accept & bus.req_we & ~misal & hit_toggle;

  // Load data source: the live request when responding straight off the accept edge, else the latched one.
  logic [31:0] rd_addr;
  logic        rd_we;
  logic        rd_bad;
  logic [31:0] rd_data;

  always_comb begin
    rd_addr = accept ? bus.req_addr : addr_q;
    rd_we   = accept ? bus.req_we   : we_q;
    rd_bad  = accept ? misal        : bad_q;
    rd_data = 32'h0;
    if (!rd_we && !rd_bad) begin
      if (rd_addr == TOGGLE_ADDR) begin
        rd_data = toggle_q;
      end else if (rd_addr == TIMER_ADDR) begin
        rd_data = timer_q;
      end else if (rd_addr < RAM_BYTES) begin
        rd_data = mem[rd_addr[AW+1:2]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i]) begin
          mem[bus.req_addr[AW+1:2]][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      toggle_q    <= 32'h0;
      timer_q     <= 32'h0;
      cnt_q       <= 4'h0;
      addr_q      <= 32'h0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      timer_q     <= timer_q + 32'd1;
      rsp_valid_q <= 1'b0;
      if (wr_toggle) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.req_be[i]) begin
            toggle_q[8*i +: 8] <= bus.req_wdata[8*i +: 8];
          end
        end
      end
      case (state_q)
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= S_RESP;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_data;
            rsp_err_q   <= rd_bad;
          end
        end
        default: begin
          if (accept) begin
            addr_q <= bus.req_addr;
            we_q   <= bus.req_we;
            bad_q  <= misal;
            if (WS == 4'd0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_data;
              rsp_err_q   <= rd_bad;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign toggle_value  = toggle_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder with zero and three wait states
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0;
  logic        rst3;
  logic [31:0] tog0;
  logic [31:0] tog3;
  int          n_cmp = 0;
  int          n_bad = 0;

  dmem_responder_if if0 ();
  dmem_responder_if if3 ();

  dmem_responder #(.WAIT_STATES(0)) u0 (.clk(clk), .reset(rst0), .bus(if0), .toggle_value(tog0));
  dmem_responder #(.WAIT_STATES(3)) u3 (.clk(clk), .reset(rst3), .bus(if3), .toggle_value(tog3));

  task automatic drive(input bit s, input logic v, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
    if (s) begin
      if3.req_valid = v; if3.req_we = we; if3.req_be = be; if3.req_addr = a; if3.req_wdata = d;
    end else begin
      if0.req_valid = v; if0.req_we = we; if0.req_be = be; if0.req_addr = a; if0.req_wdata = d;
    end
  endtask

  // One request; lat counts edges from the accept edge to the sample showing rsp_valid.
  task automatic xact(input bit s, input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [31:0] tog_next);
    drive(s, 1'b1, we, be, a, d);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tog_next = s ? tog3 : tog0;
    lat = 0; rdata = 32'hx; err = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if ((s ? if3.rsp_valid : if0.rsp_valid) === 1'b1) begin
        lat = k;
        rdata = s ? if3.rsp_rdata : if0.rsp_rdata;
        err = s ? if3.rsp_err : if0.rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL xact_timeout addr=%h: no rsp_valid within 40 cycles", a);
    end
  endtask

  logic [31:0] rd, tg;
  logic        er;
  int          lt;

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1; rst0 = 1'b0; rst3 = 1'b0;
    n_cmp++; if (if0.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready0 got %b want 1", if0.req_ready); end
    n_cmp++; if (if0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid0 got %b want 0", if0.rsp_valid); end
    n_cmp++; if (if0.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata0 got %h want 0", if0.rsp_rdata); end
    n_cmp++; if (if0.rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err0 got %b want 0", if0.rsp_err); end
    n_cmp++; if (tog0 !== 32'h0) begin n_bad++; $display("FAIL rst_toggle0 got %h want 0", tog0); end
    n_cmp++; if (if3.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready3 got %b want 1", if3.req_ready); end
    n_cmp++; if (tog3 !== 32'h0) begin n_bad++; $display("FAIL rst_toggle3 got %h want 0", tog3); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    xact(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lt, tg);
    n_cmp++; if (lt !== 1) begin n_bad++; $display("FAIL st_latency got %0d want 1", lt); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL st_rdata got %h want 0", rd); end
    xact(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, er, lt, tg);
    n_cmp++; if (lt !== 1) begin n_bad++; $display("FAIL ld_latency got %0d want 1", lt); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_rdata got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL ld_err got %b want 0", er); end
  endtask

  task automatic test_byte_lanes();
    xact(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, rd, er, lt, tg);
    xact(0, 1'b0, 4'b0001, 32'h10, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'hDE22BE44) begin n_bad++; $display("FAIL byte_lanes got %h want de22be44", rd); end
    xact(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, lt, tg);
    n_cmp++; if (lt !== 1) begin n_bad++; $display("FAIL be0_latency got %0d want 1", lt); end
    xact(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'hDE22BE44) begin n_bad++; $display("FAIL be0_noop got %h want de22be44", rd); end
  endtask

  task automatic test_mmio();
    logic [31:0] t1, t2, td;
    xact(0, 1'b1, 4'hF, 32'h34, 32'h00000001, rd, er, lt, tg);
    n_cmp++; if (tg !== 32'h1) begin n_bad++; $display("FAIL toggle_next got %h want 1", tg); end
    xact(0, 1'b0, 4'hF, 32'h34, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL toggle_load got %h want 1", rd); end
    xact(0, 1'b1, 4'b0010, 32'h34, 32'h0000AB00, rd, er, lt, tg);
    n_cmp++; if (tog0 !== 32'h0000AB01) begin n_bad++; $display("FAIL toggle_lane got %h want 0000ab01", tog0); end
    drive(0, 1'b1, 1'b0, 4'hF, 32'h38, 32'h0);
    @(posedge clk); #1;
    t1 = if0.rsp_rdata;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1; drive(0, 1'b1, 1'b0, 4'hF, 32'h38, 32'h0);
    @(posedge clk); #1;
    t2 = if0.rsp_rdata;
    n_cmp++; if (if0.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL timer_valid got %b want 1", if0.rsp_valid); end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    td = t2 - t1;
    n_cmp++; if (td !== 32'd5) begin n_bad++; $display("FAIL timer_delta got %0d want 5", td); end
  endtask

  task automatic test_unmapped();
    xact(0, 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, rd, er, lt, tg);
    xact(0, 1'b0, 4'hF, 32'h400, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_load got %h want 0", rd); end
    xact(0, 1'b1, 4'hF, 32'h400, 32'h55, rd, er, lt, tg);
    n_cmp++; if (lt !== 1) begin n_bad++; $display("FAIL unmapped_st_lat got %0d want 1", lt); end
    xact(0, 1'b0, 4'hF, 32'h0, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL unmapped_alias got %h want a5a5a5a5", rd); end
    xact(0, 1'b1, 4'hF, 32'h3FC, 32'h0BADF00D, rd, er, lt, tg);
    xact(0, 1'b0, 4'hF, 32'h3FC, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL last_word got %h want 0badf00d", rd); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(posedge clk); #1;
    n_cmp++; if (if0.rsp_rdata !== 32'hDE22BE44) begin n_bad++; $display("FAIL b2b_first got %h want de22be44", if0.rsp_rdata); end
    drive(0, 1'b1, 1'b0, 4'hF, 32'h3FC, 32'h0);
    @(posedge clk); #1;
    n_cmp++; if (if0.rsp_valid !== 1'b1 || if0.rsp_rdata !== 32'h0BADF00D) begin
      n_bad++; $display("FAIL b2b_second got v=%b %h want v=1 0badf00d", if0.rsp_valid, if0.rsp_rdata);
    end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_cmp++; if (if0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", if0.rsp_valid); end
  endtask

  task automatic test_misalign();
    xact(0, 1'b1, 4'hF, 32'h12, 32'h77777777, rd, er, lt, tg);
`ifdef DMEM_MISALIGN_ERR_EN
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL misal_store got err=%b %h want err=1 0", er, rd); end
    xact(0, 1'b0, 4'hF, 32'h10, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'hDE22BE44) begin n_bad++; $display("FAIL misal_word4 got %h want de22be44", rd); end
`else
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL misal_err got %b want 0", er); end
    xact(0, 1'b0, 4'hF, 32'h13, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'h77777777) begin n_bad++; $display("FAIL misal_word4 got %h want 77777777", rd); end
`endif
  endtask

  task automatic test_wait_states();
    logic exp_rdy, exp_val;
    xact(1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, rd, er, lt, tg);
    n_cmp++; if (lt !== 4) begin n_bad++; $display("FAIL ws3_latency got %0d want 4", lt); end
    drive(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 5) drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (k == 4) drive(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      exp_val = (k == 4 || k == 8);
      exp_rdy = exp_val;
      n_cmp++; if (if3.req_ready !== exp_rdy) begin n_bad++; $display("FAIL ws3_ready t+%0d got %b want %b", k, if3.req_ready, exp_rdy); end
      n_cmp++; if (if3.rsp_valid !== exp_val) begin n_bad++; $display("FAIL ws3_valid t+%0d got %b want %b", k, if3.rsp_valid, exp_val); end
      if (exp_val) begin
        n_cmp++; if (if3.rsp_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ws3_rdata t+%0d got %h want cafef00d", k, if3.rsp_rdata); end
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (if3.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ws3_after got %b want 0", if3.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int highs;
    xact(1, 1'b1, 4'hF, 32'h34, 32'h5, rd, er, lt, tg);
    n_cmp++; if (tg !== 32'h5) begin n_bad++; $display("FAIL ws3_toggle got %h want 5", tg); end
    drive(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    n_cmp++; if (tog3 !== 32'h0) begin n_bad++; $display("FAIL midrst_toggle got %h want 0", tog3); end
    n_cmp++; if (if3.req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", if3.req_ready); end
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      if (if3.rsp_valid !== 1'b0) highs++;
      @(posedge clk); #1;
    end
    n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL midrst_no_rsp got %0d valid cycles want 0", highs); end
    xact(1, 1'b0, 4'hF, 32'h20, 32'h0, rd, er, lt, tg);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL midrst_ram got %h want cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_mmio();
    test_unmapped();
    test_back_to_back();
    test_misalign();
    test_wait_states();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the pipeline's data-memory port.
- The MEMORY ACCESS stage issues load/store requests; this block serves them from a word-organised on-chip RAM, plus two memory-mapped registers: the LED toggle register and a free-running cycle timer.
- Models slow memory with a configurable number of wait states.
- Returns exactly one response per accepted request.

Parameters:
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of two.
- WAIT_STATES, 0: extra cycles between acceptance and response; range 0-15.
- TOGGLE_ADDR, 32'h34: byte address of the toggle register.
- TIMER_ADDR, 32'h38: byte address of the read-only cycle timer.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_be  in  4  byte enables; bit i = byte lane i (data bits 8i+7:8i)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load data; 0 for stores
- rsp_err  out  1  error flag, qualified by rsp_valid
- toggle_value  out  32  toggle register contents, drives the LED

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, toggle_value 0, timer 0, wait counter 0. RAM contents are not reset.
- State machine states: IDLE, WAIT, RESP.
- req_ready = 1 in IDLE and in RESP; 0 in WAIT.
- Accept = req_valid & req_ready. On accept, addr/we/be/wdata are latched.
- Next state after accept: WAIT_STATES = 0 -> RESP; otherwise WAIT with counter = WAIT_STATES.
- WAIT: counter decrements each cycle; when it reaches 1, next state is RESP.
- RESP: rsp_valid = 1 for exactly one cycle. If a new request is accepted in the same cycle, next state follows the accept rule; otherwise IDLE.
- Latency: rsp_valid is asserted 1 + WAIT_STATES cycles after the accept edge. Peak throughput is one request per 1 + WAIT_STATES cycles.
- No response back-pressure: the requester samples rsp_* on the cycle rsp_valid is high.
- Decode priority: TOGGLE_ADDR, then TIMER_ADDR, then RAM (addr < DEPTH_WORDS*4), then unmapped.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored.
- Stores commit on the accept edge, per enabled byte lane:
  - RAM: selected word updated.
  - TOGGLE_ADDR: toggle_value updated, visible the next cycle; the RAM word at that address is untouched.
  - TIMER_ADDR or unmapped: store dropped.
- Store response: rsp_rdata 0.
- Loads: rsp_rdata is registered on the edge entering RESP and returns the full word regardless of req_be.
  - RAM: stored word.
  - TOGGLE_ADDR: toggle_value.
  - TIMER_ADDR: timer value at that edge.
  - Unmapped: 0.
- A load accepted after a store always sees the store's data.
- Timer: 32-bit, increments every cycle, wraps 0xFFFFFFFF -> 0.
- req_be = 0: store is a no-op but still receives a response.
- Reset mid-operation: the in-flight request is abandoned and no rsp_valid is produced. A store already committed stays committed.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: a request with addr[1:0] != 0 performs no store; its response carries rsp_err = 1 and rsp_rdata = 0, with normal latency.
- Not defined: rsp_err is tied to 0 and addr[1:0] is ignored.

Test Plan:
- WAIT_STATES=0: store 0xDEADBEEF, be=4'hF, addr 0x10; then load 0x10 -> each rsp_valid lands 1 cycle after its accept; load returns 0xDEADBEEF.
- Byte lanes: store 0x11223344, be=4'b0101, addr 0x10 over 0xDEADBEEF -> load 0x10 returns 0xDE22BE44.
- MMIO:
  - Store 0x00000001 to 0x34 -> toggle_value = 1 the cycle after the accept edge; RAM word 13 unchanged; load 0x34 returns 1.
  - Loads of 0x38 accepted 5 cycles apart -> rdata values differ by 5.
- WAIT_STATES=3: load accepted at cycle t -> req_ready low t+1..t+3; rsp_valid high only at t+4. A second request accepted at t+4 gets rsp_valid at t+8.
- DEPTH_WORDS=256: load 0x400 -> rdata 0; store 0x55 to 0x400 is dropped. With DMEM_MISALIGN_ERR_EN, store to 0x12 -> rsp_err = 1 and word 4 unchanged.
- Reset asserted for 1 cycle during WAIT -> no rsp_valid; toggle_value 0; req_ready 1 the cycle after reset deasserts.
